hp_controller: RTL and testbench

HP_CONTROLLER -- requirements
Module: hp_controller

---
 rtl/game_pkg.sv | 31 +++
 rtl/invuln_timer.sv | 40 ++++
 rtl/hp_controller.sv | 123 ++++++++++++
 tb/tb_hp_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: player state encoding, HP type, parameter defaults, HP arithmetic helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package game_pkg;

    typedef logic [7:0] hp_t;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam int MAX_HP_DEFAULT        = 100;
    localparam int HEAL_AMOUNT_DEFAULT   = 5;
    localparam int INVULN_FRAMES_DEFAULT = 30;
    localparam int BLINK_SHIFT_DEFAULT   = 2;

    // Saturating subtract: damage larger than the current HP floors at zero.
    function automatic hp_t hp_sub_sat(hp_t cur, logic [7:0] dmg);
        return (dmg >= cur) ? '0 : hp_t'(cur - dmg);
    endfunction

    // Add in 9 bits so the sum cannot wrap, then clamp to the cap.
    function automatic hp_t hp_add_clamp(hp_t cur, logic [8:0] amt, hp_t cap);
        logic [8:0] sum;
        sum = {1'b0, cur} + amt;
        return (sum > {1'b0, cap}) ? cap : sum[7:0];
    endfunction

endpackage

// File: rtl/invuln_timer.sv
// Invulnerability frame countdown: load, per-frame decrement, expiry flag, blink phase bit.
// Latency: counter updates on the edge after load/tick; expire and blink_bit are combinational from the count.
// Backpressure: none; every frame_tick is consumed.
module invuln_timer #(
    parameter int INVULN_FRAMES = 30,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic frame_tick,
    output logic expire,
    output logic blink_bit
);

    logic [7:0] count;
    logic [7:0] elapsed;

    // Countdown register: clear beats load, load beats decrement, idle at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (load) begin
            count <= 8'(INVULN_FRAMES);
        end else if (frame_tick && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    // Zero flag for the next count, and frames elapsed since the hit for the blink phase.
    always_comb begin
        expire    = frame_tick && (count == 8'd1);
        elapsed   = 8'(INVULN_FRAMES) - count;
        blink_bit = elapsed[BLINK_SHIFT];
    end

endmodule

// File: rtl/hp_controller.sv
// Player HP/state controller: applies damage/heal results, invulnerability window, death and restart.
// Latency: one cycle from result_valid/frame_tick/restart to hp, state flags and hp_changed.
// Backpressure: none; every result_valid pulse is consumed or deliberately ignored by state.
module hp_controller
    import game_pkg::*;
#(
    parameter int MAX_HP        = MAX_HP_DEFAULT,
    parameter int HEAL_AMOUNT   = HEAL_AMOUNT_DEFAULT,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEFAULT,
    parameter int BLINK_SHIFT   = BLINK_SHIFT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       result_valid,
    input  logic [7:0] damage_in,
    input  logic       heal_in,
    input  logic       frame_tick,
    input  logic       restart,
    output logic [7:0] hp,
    output logic       is_dead,
    output logic       invincible,
    output logic       blink,
    output logic       hp_changed
);

    state_t state;
    hp_t    dmg_hp;
    hp_t    alive_hp;
    hp_t    invuln_hp;
    logic   timer_load;
    logic   timer_expire;
    logic   timer_blink;

    // Candidate HP values: damage first, heal only if the player survived the damage.
    always_comb begin
        dmg_hp    = hp_sub_sat(hp, damage_in);
        alive_hp  = (heal_in && (dmg_hp != 8'd0))
                  ? hp_add_clamp(dmg_hp, 9'(HEAL_AMOUNT), 8'(MAX_HP)) : dmg_hp;
        invuln_hp = heal_in ? hp_add_clamp(hp, 9'(HEAL_AMOUNT), 8'(MAX_HP)) : hp;
    end

    // A surviving hit in ALIVE starts the invulnerability countdown.
    always_comb begin
        timer_load = !restart && (state == ST_ALIVE) && result_valid
                     && (damage_in != 8'd0) && (dmg_hp != 8'd0);
    end

    invuln_timer #(
        .INVULN_FRAMES (INVULN_FRAMES),
        .BLINK_SHIFT   (BLINK_SHIFT)
    ) u_invuln_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .clear      (restart),
        .frame_tick (frame_tick),
        .expire     (timer_expire),
        .blink_bit  (timer_blink)
    );

    // Player FSM with registered hp and flags; restart overrides everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ALIVE;
            hp         <= 8'(MAX_HP);
            is_dead    <= 1'b0;
            invincible <= 1'b0;
            hp_changed <= 1'b0;
        end else begin
            hp_changed <= 1'b0;
            if (restart) begin
                state      <= ST_ALIVE;
                hp         <= 8'(MAX_HP);
                is_dead    <= 1'b0;
                invincible <= 1'b0;
                hp_changed <= (hp != 8'(MAX_HP));
            end else begin
                case (state)
                    ST_ALIVE: begin
                        if (result_valid) begin
                            hp         <= alive_hp;
                            hp_changed <= (alive_hp != hp);
                            if (damage_in != 8'd0) begin
                                if (dmg_hp == 8'd0) begin
                                    state   <= ST_DEAD;
                                    is_dead <= 1'b1;
                                end else begin
                                    state      <= ST_INVULN;
                                    invincible <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_INVULN: begin
                        // Damage is ignored here; heals still land.
                        if (result_valid) begin
                            hp         <= invuln_hp;
                            hp_changed <= (invuln_hp != hp);
                        end
                        if (timer_expire) begin
                            state      <= ST_ALIVE;
                            invincible <= 1'b0;
                        end
                    end
                    ST_DEAD: begin
                        hp <= 8'd0;
                    end
                    default: begin
                        state      <= ST_ALIVE;
                        is_dead    <= 1'b0;
                        invincible <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Blink only while invulnerable; drops with the invincible flag on exit.
    always_comb begin
        blink = invincible && timer_blink;
    end

endmodule

// File: tb/tb_hp_controller.sv
module tb_hp_controller;

    localparam int MAXHP = 100;
    localparam int HEAL  = 5;
    localparam int INV   = 30;
    localparam int BSH   = 2;

    logic       clk;
    logic       reset;
    logic       result_valid;
    logic [7:0] damage_in;
    logic       heal_in;
    logic       frame_tick;
    logic       restart;
    logic [7:0] hp;
    logic       is_dead;
    logic       invincible;
    logic       blink;
    logic       hp_changed;

    int compared;
    int mismatched;

    // Reference model: plain integers describing the player.
    int m_hp;
    int m_dead;
    int m_left;
    int m_elapsed;
    int m_chg;

    hp_controller #(
        .MAX_HP        (MAXHP),
        .HEAL_AMOUNT   (HEAL),
        .INVULN_FRAMES (INV),
        .BLINK_SHIFT   (BSH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .result_valid (result_valid),
        .damage_in    (damage_in),
        .heal_in      (heal_in),
        .frame_tick   (frame_tick),
        .restart      (restart),
        .hp           (hp),
        .is_dead      (is_dead),
        .invincible   (invincible),
        .blink        (blink),
        .hp_changed   (hp_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rs;
        int rv;
        int dmg;
        int hl;
        int ft;
        int reps;
        int e_hp;
        int e_dead;
        int e_inv;
        int e_blk;
        int e_chg;
    } vec_t;

    vec_t tbl[28];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_hp, input int e_dead,
                             input int e_inv, input int e_blk, input int e_chg);
        check({tag, " hp"},         int'(hp),         e_hp);
        check({tag, " is_dead"},    int'(is_dead),    e_dead);
        check({tag, " invincible"}, int'(invincible), e_inv);
        check({tag, " blink"},      int'(blink),      e_blk);
        check({tag, " hp_changed"}, int'(hp_changed), e_chg);
    endtask

    task automatic model_reset();
        m_hp = MAXHP; m_dead = 0; m_left = 0; m_elapsed = 0; m_chg = 0;
    endtask

    task automatic model(input int rs, input int rv, input int dmg, input int hl, input int ft);
        int old;
        int h;
        old = m_hp;
        if (rs != 0) begin
            m_hp = MAXHP; m_dead = 0; m_left = 0; m_elapsed = 0;
        end else if (m_dead == 0) begin
            if (m_left > 0) begin
                if (rv != 0 && hl != 0) m_hp = (m_hp + HEAL > MAXHP) ? MAXHP : m_hp + HEAL;
                if (ft != 0) begin
                    m_left--;
                    m_elapsed++;
                end
            end else if (rv != 0) begin
                h = m_hp - dmg;
                if (h < 0) h = 0;
                if (hl != 0 && h > 0) h = (h + HEAL > MAXHP) ? MAXHP : h + HEAL;
                if (h == 0) m_dead = 1;
                else if (dmg > 0) begin
                    m_left = INV;
                    m_elapsed = 0;
                end
                m_hp = h;
            end
        end
        m_chg = (m_hp != old) ? 1 : 0;
    endtask

    function automatic int model_blink();
        return (m_left > 0) ? ((m_elapsed >> BSH) & 1) : 0;
    endfunction

    task automatic step(input int rs, input int rv, input int dmg, input int hl, input int ft);
        restart      = rs[0];
        result_valid = rv[0];
        damage_in    = 8'(dmg);
        heal_in      = hl[0];
        frame_tick   = ft[0];
        @(posedge clk);
        #1;
        model(rs, rv, dmg, hl, ft);
        restart = 1'b0; result_valid = 1'b0; damage_in = 8'd0; heal_in = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_hp, m_dead, (m_left > 0) ? 1 : 0, model_blink(), m_chg);
    endtask

    initial begin
        int rs, rv, dmg, hl, ft, r;
        compared = 0;
        mismatched = 0;

        //            rs rv dmg hl ft reps  hp dead inv blk chg
        tbl[0]  = '{0, 1, 10, 0, 0, 1,  90, 0, 1, 0, 1};
        tbl[1]  = '{0, 1, 40, 0, 0, 1,  90, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0,  0, 1, 4,  90, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 0,  0, 1, 25, 90, 0, 1, 1, 0};
        tbl[4]  = '{0, 0, 0,  0, 1, 1,  90, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0,  1, 0, 1,  95, 0, 0, 0, 1};
        tbl[6]  = '{0, 1, 0,  1, 0, 1, 100, 0, 0, 0, 1};
        tbl[7]  = '{0, 1, 2,  0, 0, 1,  98, 0, 1, 0, 1};
        tbl[8]  = '{0, 1, 0,  1, 0, 1, 100, 0, 1, 0, 1};
        tbl[9]  = '{0, 1, 0,  1, 0, 1, 100, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 0,  0, 1, 29,100, 0, 1, 1, 0};
        tbl[11] = '{0, 1, 50, 0, 1, 1, 100, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 95, 0, 0, 1,   5, 0, 1, 0, 1};
        tbl[13] = '{0, 0, 0,  0, 1, 30,  5, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 20, 1, 0, 1,   0, 1, 0, 0, 1};
        tbl[15] = '{0, 1, 0,  1, 0, 1,   0, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 0,  0, 1, 1,   0, 1, 0, 0, 0};
        tbl[17] = '{0, 1, 10, 0, 1, 1,   0, 1, 0, 0, 0};
        tbl[18] = '{1, 1, 10, 0, 0, 1, 100, 0, 0, 0, 1};
        tbl[19] = '{0, 1, 255,0, 0, 1,   0, 1, 0, 0, 1};
        tbl[20] = '{1, 0, 0,  0, 0, 1, 100, 0, 0, 0, 1};
        tbl[21] = '{0, 1, 0,  1, 0, 1, 100, 0, 0, 0, 0};
        tbl[22] = '{0, 1, 0,  0, 0, 1, 100, 0, 0, 0, 0};
        tbl[23] = '{0, 1, 100,0, 0, 1,   0, 1, 0, 0, 1};
        tbl[24] = '{1, 0, 0,  0, 0, 1, 100, 0, 0, 0, 1};
        tbl[25] = '{0, 1, 3,  0, 1, 1,  97, 0, 1, 0, 1};
        tbl[26] = '{1, 0, 0,  0, 0, 1, 100, 0, 0, 0, 1};
        tbl[27] = '{0, 0, 0,  0, 1, 1, 100, 0, 0, 0, 0};

        // Reset state, checked while reset is still asserted.
        reset = 1'b1;
        result_valid = 1'b0; damage_in = 8'd0; heal_in = 1'b0; frame_tick = 1'b0; restart = 1'b0;
        model_reset();
        #13;
        check_all("reset", MAXHP, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_reset", MAXHP, 0, 0, 0, 0);

        // Directed table.
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].reps; k++)
                step(tbl[i].rs, tbl[i].rv, tbl[i].dmg, tbl[i].hl, tbl[i].ft);
            check_all($sformatf("vec%0d", i), tbl[i].e_hp, tbl[i].e_dead,
                      tbl[i].e_inv, tbl[i].e_blk, tbl[i].e_chg);
        end

        // Asynchronous reset in the middle of an invulnerability window.
        step(0, 1, 10, 0, 0);
        step(0, 0, 0, 0, 1);
        check_model("pre_arst_inv");
        #2 reset = 1'b1;
        #1;
        check_all("arst_inv", MAXHP, 0, 0, 0, 0);
        model_reset();
        #1 reset = 1'b0;
        step(0, 0, 0, 0, 1);
        check_all("after_arst_inv", MAXHP, 0, 0, 0, 0);

        // Asynchronous reset while dead.
        step(0, 1, 200, 0, 0);
        check_all("pre_arst_dead", 0, 1, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        check_all("arst_dead", MAXHP, 0, 0, 0, 0);
        model_reset();
        #1 reset = 1'b0;
        step(0, 1, 7, 0, 0);
        check_all("after_arst_dead", 93, 0, 1, 0, 1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 63) == 0) ? 1 : 0;
            rv = ($urandom_range(0, 9) < 4) ? 1 : 0;
            r  = $urandom_range(0, 19);
            dmg = (r < 9) ? 0 : (r < 19) ? $urandom_range(1, 40) : $urandom_range(0, 255);
            hl = ($urandom_range(0, 4) == 0) ? 1 : 0;
            ft = ($urandom_range(0, 3) == 0) ? 1 : 0;
            step(rs, rv, dmg, hl, ft);
            check_model($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
